smvm_sched: RTL

SMVM_SCHED -- requirements
Module: smvm_sched

---
 rtl/smvm_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/smvm_sched.sv
// smvm_sched: sparse matrix-vector multiply input scheduler.
// Parses a beat stream (row-count header, column-count header, dense vector,
// then value/column nonzero pairs), writes the dense vector into a vector RAM,
// and packs nonzeros into groups of K for the ALU pipeline.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input beat handshake
//   val_in, col_in, ipv_in    beat payload (header / element / nonzero fields)
//   vec_we/vec_addr/vec_wdata vector RAM write port (combinational in VEC)
//   grp_valid/grp_ready       group handshake toward the ALU pipeline
//   grp_val/grp_col/grp_ipv   group payload, slot 0 in the MSBs
//   grp_ones                  popcount of grp_ipv
//   done, err                 end-of-matrix pulse, row-count / column error
module smvm_sched #(
  parameter int unsigned K         = 4,
  parameter int unsigned VEC_DEPTH = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   val_in,
  input  logic [2:0]                   col_in,
  input  logic                         ipv_in,
  output logic                         vec_we,
  output logic [$clog2(VEC_DEPTH)-1:0] vec_addr,
  output logic [7:0]                   vec_wdata,
  output logic                         grp_valid,
  input  logic                         grp_ready,
  output logic [8*K-1:0]               grp_val,
  output logic [7*K-1:0]               grp_col,
  output logic [K-1:0]                 grp_ipv,
  output logic [2:0]                   grp_ones,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned AW = $clog2(VEC_DEPTH);
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [2:0] {
    IDLE, HDR_COL, VEC, NZ_VAL, NZ_COL, FLUSH, DONE
  } state_t;

  state_t         r_state, w_next;
  logic [7:0]     r_rows, r_cols, r_idx, r_rowcnt;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_sval [K];
  logic [6:0]     r_scol [K];
  logic [K-1:0]   r_sipv;
  logic           r_gv, r_err;
  logic [8*K-1:0] r_gval;
  logic [7*K-1:0] r_gcol;
  logic [K-1:0]   r_gipv;
  logic [2:0]     r_gones;

  logic           w_acc, w_last_vec, w_full, w_flush_load, w_load, w_err_done;
  logic [6:0]     w_col7;
  logic [8*K-1:0] w_gval;
  logic [7*K-1:0] w_gcol;
  logic [K-1:0]   w_gipv;
  logic [2:0]     w_ones;

  assign w_acc        = in_valid && in_ready;
  assign w_col7       = {val_in[3:0], col_in};
  assign w_last_vec   = (r_idx == r_cols - 8'd1);
  assign w_full       = (r_state == NZ_COL) && w_acc && (r_cnt == CW'(K - 1));
  // A flush may replace a group that is being accepted in the same cycle.
  assign w_flush_load = (r_state == FLUSH) && (r_cnt != '0) && (!r_gv || grp_ready);
  assign w_load       = w_full || w_flush_load;
  assign w_err_done   = (r_state == DONE) && (r_rowcnt != r_rows);

  // Group image: the column of the last slot is still on the input bus when
  // the group completes, so it is merged in here rather than from r_scol.
  always_comb begin
    w_gval = '0;
    w_gcol = '0;
    w_gipv = '0;
    w_ones = '0;
    for (int unsigned i = 0; i < K; i++) begin
      w_gval[8*(K-1-i) +: 8] = r_sval[i];
      w_gcol[7*(K-1-i) +: 7] = ((r_state == NZ_COL) && (CW'(i) == r_cnt)) ? w_col7 : r_scol[i];
      w_gipv[K-1-i]          = r_sipv[i];
      w_ones                 = w_ones + 3'(r_sipv[i]);
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    vec_we    = 1'b0;
    vec_addr  = r_idx[AW-1:0];
    vec_wdata = val_in;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = HDR_COL;
      end
      HDR_COL: begin
        in_ready = 1'b1;
        if (in_valid) w_next = VEC;
      end
      VEC: begin
        in_ready = 1'b1;
        vec_we   = in_valid;
        if (in_valid && w_last_vec) w_next = NZ_VAL;
      end
      NZ_VAL: begin
        in_ready = !r_gv;
        if (!in_valid)     w_next = (r_cnt != '0) ? FLUSH : DONE;
        else if (!r_gv)    w_next = NZ_COL;
      end
      NZ_COL: begin
        in_ready = !r_gv;
        if (w_acc) w_next = NZ_VAL;
      end
      FLUSH: begin
        if ((r_cnt == '0) && (!r_gv || grp_ready)) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rows   <= '0;
      r_cols   <= '0;
      r_idx    <= '0;
      r_rowcnt <= '0;
      r_cnt    <= '0;
      r_sipv   <= '0;
      r_gv     <= 1'b0;
      r_err    <= 1'b0;
      r_gval   <= '0;
      r_gcol   <= '0;
      r_gipv   <= '0;
      r_gones  <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        r_sval[i] <= '0;
        r_scol[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (in_valid) begin
          r_rows   <= val_in;
          r_rowcnt <= '0;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_err    <= 1'b0;
          r_sipv   <= '0;
          for (int unsigned i = 0; i < K; i++) begin
            r_sval[i] <= '0;
            r_scol[i] <= '0;
          end
        end
        HDR_COL: if (in_valid) r_cols <= (val_in == '0) ? 8'(VEC_DEPTH) : val_in;
        VEC: if (in_valid) r_idx <= w_last_vec ? '0 : r_idx + 8'd1;
        NZ_VAL: if (w_acc) begin
          for (int unsigned i = 0; i < K; i++) begin
            if (CW'(i) == r_cnt) begin
              r_sval[i] <= val_in;
              r_sipv[i] <= ipv_in;
            end
          end
          if (ipv_in) r_rowcnt <= r_rowcnt + 8'd1;
        end
        NZ_COL: if (w_acc) begin
          for (int unsigned i = 0; i < K; i++) begin
            if (CW'(i) == r_cnt) r_scol[i] <= w_col7;
          end
          if ({1'b0, w_col7} >= r_cols) r_err <= 1'b1;
          r_cnt <= w_full ? '0 : r_cnt + CW'(1);
        end
        FLUSH: if (w_flush_load) r_cnt <= '0;
        DONE: if (w_err_done) r_err <= 1'b1;
        default: ;
      endcase
      // Loading empties the slots so a later flush pads with zeros for free.
      if (w_load) begin
        r_gv    <= 1'b1;
        r_gval  <= w_gval;
        r_gcol  <= w_gcol;
        r_gipv  <= w_gipv;
        r_gones <= w_ones;
        r_sipv  <= '0;
        for (int unsigned i = 0; i < K; i++) begin
          r_sval[i] <= '0;
          r_scol[i] <= '0;
        end
      end else if (grp_ready) begin
        r_gv <= 1'b0;
      end
    end
  end

  assign grp_valid = r_gv;
  assign grp_val   = r_gval;
  assign grp_col   = r_gcol;
  assign grp_ipv   = r_gipv;
  assign grp_ones  = r_gones;
  assign err       = r_err | w_err_done;

endmodule
